// File: rtl/single_cycle_cpu_core.sv
// single_cycle_cpu_core: 32-bit single-cycle MIPS-subset core (PC, 32x32 register
// file, ALU, decode/control). One instruction retires per clock; instruction
// and data memories are external, combinational-read, byte-addressed.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   instruction  instruction word fetched at pc_out
//   rdata_dm     data-memory read word at alu_result (valid while rvalid=1)
//   pc_in        PC echoed by instruction memory; base for PC+4 and branches
//   pc_out       current PC register (fetch address)
//   rvalid       data-memory read enable (lw only)
//   wvalid       data-memory write enable (sw only)
//   alu_result   ALU output; data-memory address for lw/sw
//   rdata_3      register-file read data of rt; store data for sw
//   alu_overflow signed overflow of add/sub/addi in the current cycle
module single_cycle_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] rdata_dm,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out,
  output logic        rvalid,
  output logic        wvalid,
  output logic [31:0] alu_result,
  output logic [31:0] rdata_3,
  output logic        alu_overflow
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [REG_AW-1:0] RA_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  // Architectural state
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rw_reg [0:NREGS-1];

  // Instruction fields
  logic [5:0]        op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;

  assign op     = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign target = instruction[25:0];

  // Register-file read ports; r0 is hard-wired to zero
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  assign rs_val = (rs == '0) ? '0 : rw_reg[rs];
  assign rt_val = (rt == '0) ? '0 : rw_reg[rt];

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // Control decode
  alu_op_e           alu_op;
  logic              use_imm;
  logic              use_zext;
  logic              ovf_en;
  logic              reg_we;
  logic [REG_AW-1:0] wb_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              is_beq;
  logic              is_bne;
  logic              is_j;
  logic              is_jal;
  logic              is_jr;

  always_comb begin
    alu_op   = ALU_NONE;
    use_imm  = 1'b0;
    use_zext = 1'b0;
    ovf_en   = 1'b0;
    reg_we   = 1'b0;
    wb_addr  = rt;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    case (op)
      OP_RTYPE: begin
        wb_addr = rd;
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; ovf_en = 1'b1; reg_we = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; ovf_en = 1'b1; reg_we = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; reg_we = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  reg_we = 1'b1; end
          FN_NOR: begin alu_op = ALU_NOR; reg_we = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; reg_we = 1'b1; end
          FN_SLL: begin alu_op = ALU_SLL; reg_we = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; reg_we = 1'b1; end
          FN_JR:  is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; ovf_en = 1'b1; reg_we = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; use_zext = 1'b1; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; use_zext = 1'b1; reg_we = 1'b1; end
      OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; use_imm = 1'b1; mem_rd = 1'b1; reg_we = 1'b1; end
      OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; mem_wr = 1'b1; end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j = 1'b1;
      OP_JAL:  begin is_jal = 1'b1; reg_we = 1'b1; wb_addr = RA_REG; end
      default: ;
    endcase
  end

  // ALU
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_res;
  logic            ovf;

  assign alu_a = rs_val;
  assign alu_b = use_imm ? (use_zext ? imm_zext : imm_sext) : rt_val;
  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = sum;
        ovf     = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        ovf     = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_NOR: alu_res = ~(alu_a | alu_b);
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLL: alu_res = rt_val << shamt;
      ALU_SRL: alu_res = rt_val >> shamt;
      ALU_LUI: alu_res = {imm, 16'h0000};
      default: alu_res = '0;
    endcase
  end

  // Next-PC selection; all arithmetic wraps modulo 2^32
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_target;
  logic [XLEN-1:0] next_pc;
  logic            regs_equal;

  assign pc_plus4   = pc_in + XLEN'(4);
  assign br_target  = pc_plus4 + (imm_sext << 2);
  assign jmp_target = {pc_plus4[31:28], target, 2'b00};
  assign regs_equal = (rs_val == rt_val);

  always_comb begin
    next_pc = pc_plus4;
    if ((is_beq && regs_equal) || (is_bne && !regs_equal)) next_pc = br_target;
    else if (is_j || is_jal)                               next_pc = jmp_target;
    else if (is_jr)                                        next_pc = rs_val;
  end

  // Write-back data: load data, link address or ALU result
  logic [XLEN-1:0] wb_data;

  always_comb begin
    wb_data = alu_res;
    if (mem_rd)      wb_data = rdata_dm;
    else if (is_jal) wb_data = pc_plus4;
  end

  // PC and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < int'(NREGS); i++) rw_reg[i] <= '0;
    end else begin
      pc_q <= next_pc;
      if (reg_we && (wb_addr != '0)) rw_reg[wb_addr] <= wb_data;
    end
  end

  // Memory strobes are suppressed while reset is asserted
  assign pc_out       = pc_q;
  assign rvalid       = mem_rd & ~reset;
  assign wvalid       = mem_wr & ~reset;
  assign alu_result   = alu_res;
  assign rdata_3      = rt_val;
  assign alu_overflow = ovf_en & ovf;

endmodule

// File: tb/tb_single_cycle_cpu_core.sv
// Testbench for single_cycle_cpu_core: drives a directed instruction trace from
// a table (one record per retired instruction) and checks fetch PC, memory
// strobes, ALU outputs and the register written at each edge, plus hand-written
// reset sequences.
module tb_single_cycle_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] rdata_dm;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        rvalid;
  logic        wvalid;
  logic [31:0] alu_result;
  logic [31:0] rdata_3;
  logic        alu_overflow;

  always #5 clk = ~clk;

  single_cycle_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .rdata_dm     (rdata_dm),
    .pc_in        (pc_in),
    .pc_out       (pc_out),
    .rvalid       (rvalid),
    .wvalid       (wvalid),
    .alu_result   (alu_result),
    .rdata_3      (rdata_3),
    .alu_overflow (alu_overflow)
  );

  // Instruction memory echoes the fetch address; data memory is a small word array
  logic [31:0] dmem [0:63];
  assign pc_in    = pc_out;
  assign rdata_dm = dmem[alu_result[7:2]];
  always @(posedge clk) if (wvalid) dmem[alu_result[7:2]] <= rdata_3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;      // expected pc_out while this instruction executes
    logic        rv;
    logic        wv;
    logic        ov;
    logic        chk_alu;
    logic [31:0] alu;
    logic        chk_st;
    logic [31:0] st;
    logic [4:0]  rd;      // register inspected after the edge
    logic [31:0] rval;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic rv, input logic wv, input logic ov,
                              input logic chk_alu, input logic [31:0] alu,
                              input logic chk_st, input logic [31:0] st,
                              input logic [4:0] rd, input logic [31:0] rval);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rv = rv; v.wv = wv; v.ov = ov;
    v.chk_alu = chk_alu; v.alu = alu; v.chk_st = chk_st; v.st = st;
    v.rd = rd; v.rval = rval;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] or_all_regs();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.rw_reg[i];
    return acc;
  endfunction

  initial begin
    // Directed trace; pc column encodes the expected control flow
    vecs.push_back(mk(enc_i(6'h08, 0, 1, 16'h0005), 32'h00, 0,0,0, 1, 32'h5,        0, 0, 1,  32'h5));
    vecs.push_back(mk(enc_i(6'h08, 0, 2, 16'hFFFD), 32'h04, 0,0,0, 1, 32'hFFFFFFFD, 0, 0, 2,  32'hFFFFFFFD));
    vecs.push_back(mk(enc_r(1, 2, 3, 0, 6'h20),     32'h08, 0,0,0, 1, 32'h2,        0, 0, 3,  32'h2));
    vecs.push_back(mk(enc_r(2, 1, 5, 0, 6'h2A),     32'h0C, 0,0,0, 1, 32'h1,        0, 0, 5,  32'h1));
    vecs.push_back(mk(enc_i(6'h04, 0, 0, 16'h0002), 32'h10, 0,0,0, 0, 0,            0, 0, 0,  32'h0));
    vecs.push_back(mk(enc_r(1, 2, 4, 0, 6'h22),     32'h1C, 0,0,0, 1, 32'h8,        0, 0, 4,  32'h8));
    vecs.push_back(mk(enc_j(6'h03, 26'h40),         32'h20, 0,0,0, 0, 0,            0, 0, 31, 32'h24));
    vecs.push_back(mk(enc_i(6'h05, 0, 0, 16'h0002), 32'h100,0,0,0, 0, 0,            0, 0, 0,  32'h0));
    vecs.push_back(mk(enc_i(6'h08, 0, 0, 16'h0007), 32'h104,0,0,0, 1, 32'h7,        0, 0, 0,  32'h0));
    vecs.push_back(mk(enc_r(31, 0, 0, 0, 6'h08),    32'h108,0,0,0, 0, 0,            0, 0, 0,  32'h0));
    vecs.push_back(mk(enc_i(6'h0F, 0, 6, 16'h7FFF), 32'h24, 0,0,0, 1, 32'h7FFF0000, 0, 0, 6,  32'h7FFF0000));
    vecs.push_back(mk(enc_i(6'h0D, 6, 6, 16'hFFFF), 32'h28, 0,0,0, 1, 32'h7FFFFFFF, 0, 0, 6,  32'h7FFFFFFF));
    vecs.push_back(mk(enc_i(6'h08, 6, 7, 16'h0001), 32'h2C, 0,0,1, 1, 32'h80000000, 0, 0, 7,  32'h80000000));
    vecs.push_back(mk(enc_i(6'h08, 0, 1, 16'h0055), 32'h30, 0,0,0, 1, 32'h55,       0, 0, 1,  32'h55));
    vecs.push_back(mk(enc_i(6'h2B, 0, 1, 16'h0008), 32'h34, 0,1,0, 1, 32'h8,        1, 32'h55, 0, 32'h0));
    vecs.push_back(mk(enc_i(6'h23, 0, 8, 16'h0008), 32'h38, 1,0,0, 1, 32'h8,        0, 0, 8,  32'h55));
    vecs.push_back(mk(enc_i(6'h0D, 0, 1, 16'hF0F0), 32'h3C, 0,0,0, 1, 32'hF0F0,     0, 0, 1,  32'hF0F0));
    vecs.push_back(mk(enc_i(6'h0C, 1, 2, 16'h00FF), 32'h40, 0,0,0, 1, 32'hF0,       0, 0, 2,  32'hF0));
    vecs.push_back(mk(enc_r(0, 0, 3, 0, 6'h27),     32'h44, 0,0,0, 1, 32'hFFFFFFFF, 0, 0, 3,  32'hFFFFFFFF));
    vecs.push_back(mk(enc_r(0, 1, 4, 4, 6'h00),     32'h48, 0,0,0, 1, 32'h000F0F00, 0, 0, 4,  32'h000F0F00));
    vecs.push_back(mk(enc_r(0, 4, 9, 8, 6'h02),     32'h4C, 0,0,0, 1, 32'h00000F0F, 0, 0, 9,  32'h00000F0F));
    vecs.push_back(mk(enc_i(6'h3F, 1, 1, 16'h1234), 32'h50, 0,0,0, 0, 0,            0, 0, 1,  32'hF0F0));
    vecs.push_back(mk(enc_r(7, 1, 10, 0, 6'h22),    32'h54, 0,0,1, 1, 32'h7FFF0F10, 0, 0, 10, 32'h7FFF0F10));
    vecs.push_back(mk(enc_i(6'h0A, 3, 11, 16'h0001),32'h58, 0,0,0, 1, 32'h1,        0, 0, 11, 32'h1));
    vecs.push_back(mk(enc_j(6'h02, 26'h30),         32'h5C, 0,0,0, 0, 0,            0, 0, 0,  32'h0));
    vecs.push_back(mk(enc_r(7, 7, 12, 0, 6'h20),    32'hC0, 0,0,1, 1, 32'h0,        0, 0, 12, 32'h0));
    vecs.push_back(mk(enc_r(1, 1, 13, 0, 6'h3F),    32'hC4, 0,0,0, 0, 0,            0, 0, 13, 32'h0));

    // Reset: a store/load presented during reset must not strobe memory
    reset       = 1'b1;
    instruction = enc_i(6'h2B, 0, 1, 16'h0008);
    @(posedge clk); #1;
    check("reset_wvalid", 32'(wvalid), 32'h0);
    instruction = enc_i(6'h23, 0, 8, 16'h0008);
    #1;
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_pc", pc_out, 32'h0);
    check("reset_regs", or_all_regs(), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven trace
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      instruction = v.instr;
      #1;
      check($sformatf("v%0d_pc", i), pc_out, v.pc);
      check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v.rv));
      check($sformatf("v%0d_wvalid", i), 32'(wvalid), 32'(v.wv));
      check($sformatf("v%0d_ovf", i), 32'(alu_overflow), 32'(v.ov));
      if (v.chk_alu) check($sformatf("v%0d_alu", i), alu_result, v.alu);
      if (v.chk_st)  check($sformatf("v%0d_rdata3", i), rdata_3, v.st);
      @(posedge clk); #1;
      check($sformatf("v%0d_r%0d", i, v.rd), dut.rw_reg[v.rd], v.rval);
    end

    // Mid-run reset clears PC and every register
    instruction = enc_i(6'h2B, 0, 1, 16'h0008);
    #1;
    check("end_pc", pc_out, 32'hC8);
    check("end_regs_nonzero", 32'(or_all_regs() != 0), 32'h1);
    reset = 1'b1;
    #1;
    check("midreset_wvalid", 32'(wvalid), 32'h0);
    @(posedge clk); #1;
    check("midreset_pc", pc_out, 32'h0);
    check("midreset_regs", or_all_regs(), 32'h0);
    check("sw_stored", dmem[2], 32'h55);

    // First fetch after release: PC advances by 4 and the write lands
    reset       = 1'b0;
    instruction = enc_i(6'h08, 0, 1, 16'h0009);
    #1;
    check("rel_alu", alu_result, 32'h9);
    @(posedge clk); #1;
    check("rel_pc", pc_out, 32'h4);
    check("rel_r1", dut.rw_reg[1], 32'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/single_cycle_cpu_core.md
Name: single_cycle_cpu_core

Overview:
- Single-cycle, 32-bit, MIPS-subset CPU datapath and control; one instruction retires per clock.
- Owns the PC register, a 32x32 register file (array named rw_reg, indexed 0..31) and the ALU.
- Instruction memory and data memory are external. Both are byte-addressed, big-endian and combinational-read.
- The core drives the instruction/data addresses and samples the returned words within the same cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instruction  input  32  instruction word fetched at pc_out. Combinational from instruction memory.
- rdata_dm  input  32  data-memory read word at alu_result. Combinational, valid while rvalid=1.
- pc_in  input  32  PC echoed back by instruction memory, equal to pc_out. Used for PC+4 and branch target.
- pc_out  output  32  current PC register (fetch address).
- rvalid  output  1  data-memory read enable; 1 only for lw.
- wvalid  output  1  data-memory write enable; 1 only for sw. Memory writes on the rising edge.
- alu_result  output  32  ALU output; the data-memory address for lw/sw.
- rdata_3  output  32  register-file read data of rt; the store data for sw.
- alu_overflow  output  1  signed overflow of add/sub/addi in the current cycle.

Behaviour:
- Reset, at posedge with reset=1:
  - PC <= RESET_PC; all rw_reg <= 0.
  - No register write.
  - rvalid/wvalid forced 0 while reset=1.
  - alu_result, rdata_3 and alu_overflow follow the combinational datapath.
- Each posedge with reset=0:
  - PC <= next_pc.
  - Register write if enabled.
  - Data-memory write by the external memory if wvalid=1.
- Register file:
  - Two combinational read ports (rs, rt) and one synchronous write port.
  - Writes to r0 are ignored; r0 always reads 0.
  - Read-during-write returns the old value.
- Field decode: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
- Immediates: sign-extended except andi/ori (zero-extended) and lui (imm<<16).
- R-type (op=0), dest rd, ALU on rs/rt:
  - add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27.
  - slt 0x2A: signed compare, result 1 or 0.
  - sll 0x00, srl 0x02: rt shifted by shamt.
  - jr 0x08: next_pc = rs, no write.
- I-type, dest rt:
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F.
  - lw 0x23: addr = rs+sext(imm); rt <= rdata_dm.
  - sw 0x2B: addr = rs+sext(imm); store rt; no register write.
- Branches: beq 0x04 / bne 0x05.
  - Taken: next_pc = pc_in+4+(sext(imm)<<2). Otherwise next_pc = pc_in+4.
- Jumps:
  - j 0x02: next_pc = {pc_in+4 [31:28], target, 2'b00}.
  - jal 0x03: same target; r31 <= pc_in+4.
- Default next_pc = pc_in+4.
- Unknown opcode/funct: treated as NOP. No register write, no memory access, PC+4.
- Overflow:
  - alu_overflow=1 when add, sub or addi produces signed overflow; 0 for all other operations.
  - The destination is still written with the wrapped 32-bit result. No trap.
- Address wrap: PC arithmetic is modulo 2^32. The core does not check alignment.
- Latency:
  - Register-file and memory results are visible the cycle after the instruction executes.
  - lw data is written to the register file at the same edge that ends the lw cycle.

Test Plan:
- Reset: hold reset over 1 edge, then release -> pc_out=0, all rw_reg=0, rvalid=wvalid=0. First fetch at 0, pc_out=4 after the next edge.
- Arithmetic: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sub r4,r1,r2; slt r5,r2,r1 -> r1=5, r2=0xFFFFFFFD, r3=2, r4=8, r5=1. Writing r0 leaves r0=0.
- Overflow: lui r6,0x7FFF; ori r6,r6,0xFFFF; addi r7,r6,1 -> alu_overflow=1 during the addi cycle, r7=0x80000000.
- Memory: addi r1,r0,0x55; sw r1,8(r0); lw r8,8(r0):
  - sw cycle: wvalid=1, alu_result=8, rdata_3=0x55.
  - lw cycle: rvalid=1.
  - Then r8=0x55.
- Branch/jump:
  - beq r0,r0,+2 at PC 0x10 -> next PC 0x1C.
  - bne r0,r0,+2 -> PC+4.
  - jal 0x40 at PC 0x20 -> PC 0x100, r31=0x24.
  - jr r31 -> PC 0x24.
- Logic/shift: ori r1,r0,0xF0F0; andi r2,r1,0x00FF; nor r3,r0,r0; sll r4,r1,4 -> r2=0xF0, r3=0xFFFFFFFF, r4=0x000F0F00.
